// File: rtl/penalty_round_scheduler.sv
// -----------------------------------------------------------------------------
// penalty_round_scheduler
//
// Match-level sequencer for a penalty shootout. It alternates the local player
// between shooter and keeper roles, collects each round's result from the
// shooter/keeper round controllers, keeps both scores and kick counts, applies
// the regulation and sudden-death rules (with early termination), and reports
// match end and the winner.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           pulse: begin a new match (honoured only in S_IDLE / S_OVER)
//   abort           pulse: return to S_IDLE and clear everything (top priority)
//   first_shooter   sampled on an accepted start: 1 = local player shoots first
//   sh_done         pulse: local kick finished; sh_scored valid in that cycle
//   gk_done         pulse: enemy kick finished; gk_conceded valid in that cycle
//   role            00 idle, 01 shooter, 10 keeper, 11 match over
//   round_start     one-cycle pulse on the first cycle of S_SHOOT / S_KEEP
//   score_player    local goals (saturating)
//   score_enemy     enemy goals (saturating)
//   kicks_player    local kicks taken (saturating at 31)
//   kicks_enemy     enemy kicks taken (saturating at 31)
//   sudden_death    set once both sides have taken ROUNDS kicks
//   match_over      level, high in S_OVER
//   player_won      valid while match_over is high
//   dbg_state       current FSM state, for checkers and debug
//
// Handshake: sh_done and gk_done are single-cycle strobes with no ready/back-
// pressure. A strobe is consumed only when the FSM is in the matching state
// (sh_done in S_SHOOT, gk_done in S_KEEP); in any other cycle it is dropped.
// The qualifier (sh_scored / gk_conceded) is only looked at in a consumed
// strobe cycle.
//
// All outputs are registered: the combinational block computes the next value
// of every register, and a single clocked block loads them.
// -----------------------------------------------------------------------------
module penalty_round_scheduler #(
  parameter int          ROUNDS     = 5,
  parameter logic [31:0] GAP_CYCLES = 32'd6_500_000,
  parameter int          SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               first_shooter,
  input  logic               sh_done,
  input  logic               sh_scored,
  input  logic               gk_done,
  input  logic               gk_conceded,
  output logic [1:0]         role,
  output logic               round_start,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_enemy,
  output logic [4:0]         kicks_player,
  output logic [4:0]         kicks_enemy,
  output logic               sudden_death,
  output logic               match_over,
  output logic               player_won,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_SHOOT = 3'd2,
    S_KEEP  = 3'd3,
    S_CHECK = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] ROLE_IDLE  = 2'b00;
  localparam logic [1:0] ROLE_SHOOT = 2'b01;
  localparam logic [1:0] ROLE_KEEP  = 2'b10;
  localparam logic [1:0] ROLE_OVER  = 2'b11;

  localparam logic [4:0]         ROUNDS_K  = 5'(ROUNDS);
  localparam logic [4:0]         KICK_MAX  = 5'd31;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [31:0]        GAP_LAST  = GAP_CYCLES - 32'd1;

  // Wide enough that score + remaining kicks can never overflow.
  localparam int CW = SCORE_W + 6;

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  state_t             state,          state_d;
  logic [31:0]        gap_cnt,        gap_cnt_d;
  logic               next_is_shoot,  next_is_shoot_d;
  logic [1:0]         role_d;
  logic               round_start_d;
  logic [SCORE_W-1:0] score_player_d, score_enemy_d;
  logic [4:0]         kicks_player_d, kicks_enemy_d;
  logic               sudden_death_d, match_over_d, player_won_d;

  // ---------------------------------------------------------------------------
  // Match decision, evaluated on the registered (already updated) counters.
  // It is only acted upon in S_CHECK, which is entered one cycle after the
  // counters were bumped, so the values seen here include the last kick.
  // ---------------------------------------------------------------------------
  logic          regulation;
  logic [CW-1:0] sp_w, se_w, left_p, left_e;
  logic          player_ahead, enemy_ahead, decided;

  assign regulation = (kicks_player < ROUNDS_K) || (kicks_enemy < ROUNDS_K);
  assign sp_w       = CW'(score_player);
  assign se_w       = CW'(score_enemy);
  // Remaining kicks clamp at zero so a side that has finished cannot go negative.
  assign left_p     = (kicks_player >= ROUNDS_K) ? '0 : CW'(ROUNDS_K - kicks_player);
  assign left_e     = (kicks_enemy  >= ROUNDS_K) ? '0 : CW'(ROUNDS_K - kicks_enemy);
  // A side has won in regulation when the other cannot catch up even by
  // scoring every one of its remaining kicks.
  assign player_ahead = sp_w > (se_w + left_e);
  assign enemy_ahead  = se_w > (sp_w + left_p);
  // Sudden death is only settled once both sides have kicked the same number
  // of times; a lead after only one side's kick is not yet decisive.
  assign decided = regulation ? (player_ahead || enemy_ahead)
                              : ((kicks_player == kicks_enemy) &&
                                 (score_player != score_enemy));

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state;
    gap_cnt_d       = gap_cnt;
    next_is_shoot_d = next_is_shoot;
    role_d          = role;
    round_start_d   = 1'b0;
    score_player_d  = score_player;
    score_enemy_d   = score_enemy;
    kicks_player_d  = kicks_player;
    kicks_enemy_d   = kicks_enemy;
    sudden_death_d  = sudden_death;
    match_over_d    = match_over;
    player_won_d    = player_won;

    if (abort) begin
      state_d         = S_IDLE;
      gap_cnt_d       = '0;
      next_is_shoot_d = 1'b0;
      role_d          = ROLE_IDLE;
      score_player_d  = '0;
      score_enemy_d   = '0;
      kicks_player_d  = '0;
      kicks_enemy_d   = '0;
      sudden_death_d  = 1'b0;
      match_over_d    = 1'b0;
      player_won_d    = 1'b0;
    end else begin
      case (state)
        // A new match may start from idle or straight from the result screen.
        S_IDLE, S_OVER: begin
          if (start) begin
            state_d         = S_GAP;
            gap_cnt_d       = '0;
            next_is_shoot_d = first_shooter;
            role_d          = ROLE_IDLE;
            score_player_d  = '0;
            score_enemy_d   = '0;
            kicks_player_d  = '0;
            kicks_enemy_d   = '0;
            sudden_death_d  = 1'b0;
            match_over_d    = 1'b0;
            player_won_d    = 1'b0;
          end
        end

        // Idle pause between rounds; role keeps showing the last round.
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_d     = '0;
            round_start_d = 1'b1;
            if (next_is_shoot) begin
              state_d = S_SHOOT;
              role_d  = ROLE_SHOOT;
            end else begin
              state_d = S_KEEP;
              role_d  = ROLE_KEEP;
            end
          end else begin
            gap_cnt_d = gap_cnt + 32'd1;
          end
        end

        S_SHOOT: begin
          if (sh_done) begin
            if (sh_scored && (score_player != SCORE_MAX)) begin
              score_player_d = score_player + SCORE_ONE;
            end
            if (kicks_player != KICK_MAX) begin
              kicks_player_d = kicks_player + 5'd1;
            end
            next_is_shoot_d = 1'b0;
            state_d         = S_CHECK;
          end
        end

        S_KEEP: begin
          if (gk_done) begin
            if (gk_conceded && (score_enemy != SCORE_MAX)) begin
              score_enemy_d = score_enemy + SCORE_ONE;
            end
            if (kicks_enemy != KICK_MAX) begin
              kicks_enemy_d = kicks_enemy + 5'd1;
            end
            next_is_shoot_d = 1'b1;
            state_d         = S_CHECK;
          end
        end

        S_CHECK: begin
          if (!regulation) begin
            sudden_death_d = 1'b1;
          end
          if (decided) begin
            state_d      = S_OVER;
            role_d       = ROLE_OVER;
            match_over_d = 1'b1;
            player_won_d = (score_player > score_enemy);
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      next_is_shoot <= 1'b0;
      role          <= ROLE_IDLE;
      round_start   <= 1'b0;
      score_player  <= '0;
      score_enemy   <= '0;
      kicks_player  <= '0;
      kicks_enemy   <= '0;
      sudden_death  <= 1'b0;
      match_over    <= 1'b0;
      player_won    <= 1'b0;
    end else begin
      state         <= state_d;
      gap_cnt       <= gap_cnt_d;
      next_is_shoot <= next_is_shoot_d;
      role          <= role_d;
      round_start   <= round_start_d;
      score_player  <= score_player_d;
      score_enemy   <= score_enemy_d;
      kicks_player  <= kicks_player_d;
      kicks_enemy   <= kicks_enemy_d;
      sudden_death  <= sudden_death_d;
      match_over    <= match_over_d;
      player_won    <= player_won_d;
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Embedded invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // The result-screen flag and the "match over" role always travel together.
  a_over_role : assert property (@(posedge clk) disable iff (rst)
    match_over == (role == ROLE_OVER));

  // A round can only start in one of the two playing roles.
  a_round_start_role : assert property (@(posedge clk) disable iff (rst)
    round_start |-> ((role == ROLE_SHOOT) || (role == ROLE_KEEP)));

  // Playing states always show their own role.
  a_shoot_role : assert property (@(posedge clk) disable iff (rst)
    (state == S_SHOOT) |-> (role == ROLE_SHOOT));
  a_keep_role : assert property (@(posedge clk) disable iff (rst)
    (state == S_KEEP) |-> (role == ROLE_KEEP));
`endif

endmodule
